// File: rtl/mps_pkg.sv
// rtl/mps_pkg.sv - shared constants and helpers for the multi-channel pulse synchroniser
package mps_pkg;

   localparam int EDGE_RISE   = 0;
   localparam int EDGE_FALL   = 1;
   localparam int EDGE_BOTH   = 2;
   localparam int STRETCH_MAX = 255;

   // Bits needed to hold 0..stretch, i.e. ceil(log2(stretch+1)), never below 1
   function automatic int cnt_width(input int stretch);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < stretch + 1) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/multi_pulse_sync_if.sv
// rtl/multi_pulse_sync_if.sv - per-channel event inputs and synchronised outputs
interface multi_pulse_sync_if #(
   parameter int CH = 4
);
   logic [CH-1:0] async_in;
   logic [CH-1:0] enable;
   logic [CH-1:0] ovf_clr;
   logic [CH-1:0] level_out;
   logic [CH-1:0] pulse_out;
   logic [CH-1:0] overflow;

   modport master (
      output async_in,
      output enable,
      output ovf_clr,
      input  level_out,
      input  pulse_out,
      input  overflow
   );

   modport slave (
      input  async_in,
      input  enable,
      input  ovf_clr,
      output level_out,
      output pulse_out,
      output overflow
   );
endinterface

// File: rtl/mps_sync_chain.sv
// rtl/mps_sync_chain.sv - one-bit multi-flop synchroniser with async reset
module mps_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_slow,
   input  logic sys_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // Shift the asynchronous level through the flop chain; bit 0 is the capture flop
   always_ff @(posedge clk_slow or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/multi_pulse_sync.sv
// rtl/multi_pulse_sync.sv - multi-channel edge-to-stretched-pulse synchroniser (optional MPS_GLITCH_FILTER_EN)
module multi_pulse_sync
   import mps_pkg::*;
#(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0,
   parameter int STRETCH     = 1
) (
   input logic               clk_slow,
   input logic               sys_rst_n,
   multi_pulse_sync_if.slave bus
);

   localparam int STRETCH_C = (STRETCH > STRETCH_MAX) ? STRETCH_MAX : STRETCH;
   localparam int CW        = cnt_width(STRETCH_C);
   localparam logic [CW-1:0] LOAD = CW'(STRETCH_C);

   logic [CH-1:0] w_sync_q;
   logic [CH-1:0] w_level_nxt;
   logic [CH-1:0] w_edge;
   logic [CH-1:0] w_fire;
   logic [CH-1:0] w_ovf_set;
   logic [CW-1:0] w_cnt_nxt [CH];

   logic [CH-1:0] r_level;
   logic [CH-1:0] r_hist;
   logic [CH-1:0] r_pulse;
   logic [CH-1:0] r_ovf;
   logic [CW-1:0] r_cnt [CH];

   for (genvar g = 0; g < CH; g++) begin : g_ch
      mps_sync_chain #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk_slow  (clk_slow),
         .sys_rst_n (sys_rst_n),
         .i_d       (bus.async_in[g]),
         .o_q       (w_sync_q[g])
      );
   end

`ifdef MPS_GLITCH_FILTER_EN
   // The extra flop lengthens the chain by one; the level only follows once both ends agree
   logic [CH-1:0] r_sync_x;

   // One more synchroniser stage per channel, used as the filter's comparison partner
   always_ff @(posedge clk_slow or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync_x <= '0;
      end else begin
         r_sync_x <= w_sync_q;
      end
   end

   assign w_level_nxt = (r_sync_x & ~(r_sync_x ^ w_sync_q)) | (r_level & (r_sync_x ^ w_sync_q));
`else
   assign w_level_nxt = w_sync_q;
`endif

   // Edge qualification: current level against the previous cycle's level
   always_comb begin
      w_edge = '0;
      if (EDGE_MODE == EDGE_RISE) begin
         w_edge = r_level & ~r_hist;
      end else if (EDGE_MODE == EDGE_FALL) begin
         w_edge = ~r_level & r_hist;
      end else begin
         w_edge = r_level ^ r_hist;
      end
   end

   // Stretch counter next state: an enabled edge reloads, otherwise count down to zero
   always_comb begin
      w_fire    = w_edge & bus.enable;
      w_ovf_set = '0;
      for (int i = 0; i < CH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_fire[i]) begin
            w_cnt_nxt[i] = LOAD;
            w_ovf_set[i] = (r_cnt[i] != '0);
         end else if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - CW'(1);
         end
      end
   end

   // Level/history pipeline, counters, registered pulse and sticky overflow (set beats clear)
   always_ff @(posedge clk_slow or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_level <= '0;
         r_hist  <= '0;
         r_pulse <= '0;
         r_ovf   <= '0;
         for (int i = 0; i < CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_level <= w_level_nxt;
         r_hist  <= r_level;
         r_ovf   <= (r_ovf & ~bus.ovf_clr) | w_ovf_set;
         for (int i = 0; i < CH; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_pulse[i] <= (w_cnt_nxt[i] != '0);
         end
      end
   end

   assign bus.level_out = r_level;
   assign bus.pulse_out = r_pulse;
   assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_multi_pulse_sync.sv
// tb/tb_multi_pulse_sync.sv - self-checking bench: three configurations against an index-based reference model
module tb_multi_pulse_sync;

   localparam int NI  = 3;
   localparam int CH  = 4;
`ifdef MPS_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   localparam int SS0 = 2, MD0 = 0, ST0 = 1;
   localparam int SS1 = 3, MD1 = 1, ST1 = 5;
   localparam int SS2 = 2, MD2 = 2, ST2 = 8;

   logic          clk_slow = 1'b0;
   logic          sys_rst_n;
   logic [CH-1:0] async_in;
   logic [CH-1:0] enable;
   logic [CH-1:0] ovf_clr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_slow = ~clk_slow;

   multi_pulse_sync_if #(.CH(CH)) if0 ();
   multi_pulse_sync_if #(.CH(CH)) if1 ();
   multi_pulse_sync_if #(.CH(CH)) if2 ();

   assign if0.async_in = async_in;
   assign if0.enable   = enable;
   assign if0.ovf_clr  = ovf_clr;
   assign if1.async_in = async_in;
   assign if1.enable   = enable;
   assign if1.ovf_clr  = ovf_clr;
   assign if2.async_in = async_in;
   assign if2.enable   = enable;
   assign if2.ovf_clr  = ovf_clr;

   multi_pulse_sync #(.CH(CH), .SYNC_STAGES(SS0), .EDGE_MODE(MD0), .STRETCH(ST0)) u0 (
      .clk_slow (clk_slow), .sys_rst_n (sys_rst_n), .bus (if0.slave));
   multi_pulse_sync #(.CH(CH), .SYNC_STAGES(SS1), .EDGE_MODE(MD1), .STRETCH(ST1)) u1 (
      .clk_slow (clk_slow), .sys_rst_n (sys_rst_n), .bus (if1.slave));
   multi_pulse_sync #(.CH(CH), .SYNC_STAGES(SS2), .EDGE_MODE(MD2), .STRETCH(ST2)) u2 (
      .clk_slow (clk_slow), .sys_rst_n (sys_rst_n), .bus (if2.slave));

   // Reference model: inputs are recorded by edge index since reset release;
   // level after edge k is the input seen SYNC_STAGES edges earlier.
   logic [CH-1:0] ahist [$];
   int            k;
   logic [CH-1:0] m_lvl [NI];
   logic [CH-1:0] m_hst [NI];
   logic [CH-1:0] m_ovf [NI];
   int            m_rem [NI][CH];

   function automatic int p_ss(input int m);
      case (m)
         0:       return SS0;
         1:       return SS1;
         default: return SS2;
      endcase
   endfunction

   function automatic int p_md(input int m);
      case (m)
         0:       return MD0;
         1:       return MD1;
         default: return MD2;
      endcase
   endfunction

   function automatic int p_st(input int m);
      case (m)
         0:       return ST0;
         1:       return ST1;
         default: return ST2;
      endcase
   endfunction

   function automatic logic [CH-1:0] get_a(input int idx);
      if (idx >= 1 && idx <= ahist.size()) return ahist[idx-1];
      return '0;
   endfunction

   function automatic logic [CH-1:0] m_pulse(input int m);
      logic [CH-1:0] p;
      for (int c = 0; c < CH; c++) p[c] = (m_rem[m][c] != 0);
      return p;
   endfunction

   task automatic model_reset();
      ahist.delete();
      k = 0;
      for (int m = 0; m < NI; m++) begin
         m_lvl[m] = '0;
         m_hst[m] = '0;
         m_ovf[m] = '0;
         for (int c = 0; c < CH; c++) m_rem[m][c] = 0;
      end
   endtask

   task automatic model_edge();
      logic [CH-1:0] ev, set, nl, x, y, agree;
      k++;
      ahist.push_back(async_in);
      for (int m = 0; m < NI; m++) begin
         case (p_md(m))
            0:       ev = m_lvl[m] & ~m_hst[m];
            1:       ev = ~m_lvl[m] & m_hst[m];
            default: ev = m_lvl[m] ^ m_hst[m];
         endcase
         ev  = ev & enable;
         set = '0;
         for (int c = 0; c < CH; c++) begin
            if (ev[c]) begin
               if (m_rem[m][c] > 0) set[c] = 1'b1;
               m_rem[m][c] = p_st(m);
            end else if (m_rem[m][c] > 0) begin
               m_rem[m][c]--;
            end
         end
         m_ovf[m] = (m_ovf[m] & ~ovf_clr) | set;
         if (FILT != 0) begin
            x     = get_a(k - p_ss(m) - 1);
            y     = get_a(k - p_ss(m));
            agree = ~(x ^ y);
            nl    = (agree & x) | (~agree & m_lvl[m]);
         end else begin
            nl = get_a(k - p_ss(m));
         end
         m_hst[m] = m_lvl[m];
         m_lvl[m] = nl;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("u0.level_out", 32'(if0.level_out), 32'(m_lvl[0]));
      chk("u0.pulse_out", 32'(if0.pulse_out), 32'(m_pulse(0)));
      chk("u0.overflow",  32'(if0.overflow),  32'(m_ovf[0]));
      chk("u1.level_out", 32'(if1.level_out), 32'(m_lvl[1]));
      chk("u1.pulse_out", 32'(if1.pulse_out), 32'(m_pulse(1)));
      chk("u1.overflow",  32'(if1.overflow),  32'(m_ovf[1]));
      chk("u2.level_out", 32'(if2.level_out), 32'(m_lvl[2]));
      chk("u2.pulse_out", 32'(if2.pulse_out), 32'(m_pulse(2)));
      chk("u2.overflow",  32'(if2.overflow),  32'(m_ovf[2]));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".u0"}, 32'({if0.level_out, if0.pulse_out, if0.overflow}), 32'd0);
      chk({tag, ".u1"}, 32'({if1.level_out, if1.pulse_out, if1.overflow}), 32'd0);
      chk({tag, ".u2"}, 32'({if2.level_out, if2.pulse_out, if2.overflow}), 32'd0);
   endtask

   // Drive one vector, advance one edge, then compare on the falling edge
   task automatic cyc(input logic [CH-1:0] a, input logic [CH-1:0] en, input logic [CH-1:0] clr);
      async_in = a;
      enable   = en;
      ovf_clr  = clr;
      @(posedge clk_slow);
      model_edge();
      n_vec++;
      @(negedge clk_slow);
      check_all();
   endtask

   task automatic idle(input int n, input logic [CH-1:0] a);
      for (int i = 0; i < n; i++) cyc(a, '1, '0);
   endtask

   initial begin
      int cnt0, cnt1, cnt2;
      int pc0 [CH];
      int pc2 [CH];
      logic [CH-1:0] ra, ren, rclr;
      int hold;

      sys_rst_n = 1'b0;
      async_in  = '0;
      enable    = '1;
      ovf_clr   = '0;
      model_reset();
      repeat (2) @(negedge clk_slow);
      check_zero("reset_state");
      sys_rst_n = 1'b1;

      // Single rising event on channel 2
      for (int j = 1; j <= 14; j++) begin
         cyc((j <= 5) ? 4'b0100 : 4'b0000, '1, '0);
         chk("t1.u0.pulse2", 32'(if0.pulse_out[2]), 32'(j == 4 + FILT));
         chk("t1.u0.level2", 32'(if0.level_out[2]), 32'(j >= 3 + FILT && j <= 7 + FILT));
         chk("t1.u0.others", 32'({if0.pulse_out[3], if0.pulse_out[1:0]}), 32'd0);
      end
      idle(12, '0);

      // Long pulse on channel 0: stretched widths per configuration
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      for (int j = 1; j <= 30; j++) begin
         cyc((j <= 10) ? 4'b0001 : 4'b0000, '1, '0);
         if (if0.pulse_out[0] === 1'b1) cnt0++;
         if (if1.pulse_out[0] === 1'b1) cnt1++;
         if (if2.pulse_out[0] === 1'b1) cnt2++;
      end
      chk("t2.u0.width", 32'(cnt0), 32'd1);
      chk("t2.u1.width", 32'(cnt1), 32'd5);
      chk("t2.u2.width", 32'(cnt2), 32'd16);
      chk("t2.u1.ovf0",  32'(if1.overflow[0]), 32'd0);
      idle(8, '0);

      // Channel 1 toggling every 4 cycles: continuous retriggered pulse on u2
      for (int j = 1; j <= 32; j++) begin
         cyc(((((j - 1) / 4) % 2) == 0) ? 4'b0010 : 4'b0000, '1, '0);
         if (j >= 8 + FILT) chk("t3.u2.cont1", 32'(if2.pulse_out[1]), 32'd1);
      end
      chk("t3.u2.ovf1_set", 32'(if2.overflow[1]), 32'd1);
      idle(14, '0);
      cyc('0, '1, 4'b0010);
      chk("t3.u2.ovf1_clr", 32'(if2.overflow[1]), 32'd0);
      idle(4, '0);

      // Channel 3 disabled: level follows, no pulses
      for (int j = 1; j <= 24; j++) begin
         cyc((j <= 18 && (((j - 1) / 3) % 2) == 0) ? 4'b1000 : 4'b0000, 4'b0111, '0);
         chk("t4.u0.nopulse3", 32'(if0.pulse_out[3]), 32'd0);
         chk("t4.u2.nopulse3", 32'(if2.pulse_out[3]), 32'd0);
      end
      cnt0 = 0;
      for (int j = 1; j <= 10; j++) begin
         cyc(4'b1000, '1, '0);
         if (if0.pulse_out[3] === 1'b1) cnt0++;
      end
      chk("t4.u0.reenabled3", 32'(cnt0), 32'd1);
      idle(14, '0);

      // Reset mid-stretch, then release with every input high
      idle(6, 4'b0001);
      chk("t5.u2.midstretch", 32'(if2.pulse_out[0]), 32'd1);
      sys_rst_n = 1'b0;
      async_in  = 4'hF;
      #1;
      check_zero("t5.async_reset");
      model_reset();
      repeat (2) begin
         @(negedge clk_slow);
         check_zero("t5.held_reset");
      end
      sys_rst_n = 1'b1;
      for (int c = 0; c < CH; c++) begin
         pc0[c] = 0;
         pc2[c] = 0;
      end
      for (int j = 1; j <= 20; j++) begin
         cyc(4'hF, '1, '0);
         for (int c = 0; c < CH; c++) begin
            if (if0.pulse_out[c] === 1'b1) pc0[c]++;
            if (if2.pulse_out[c] === 1'b1) pc2[c]++;
         end
      end
      for (int c = 0; c < CH; c++) begin
         chk("t5.u0.one_pulse", 32'(pc0[c]), 32'd1);
         chk("t5.u2.one_pulse", 32'(pc2[c]), 32'd8);
      end
      idle(14, '0);

      // Single-cycle glitch, then a 4-cycle pulse
      cnt0 = 0;
      for (int j = 1; j <= 10; j++) begin
         cyc((j == 1) ? 4'b0001 : 4'b0000, '1, '0);
         if (if0.level_out[0] === 1'b1) cnt0++;
      end
      chk("t6.u0.glitch_level", 32'(cnt0), 32'((FILT != 0) ? 0 : 1));
      for (int j = 1; j <= 12; j++) begin
         cyc((j <= 4) ? 4'b0001 : 4'b0000, '1, '0);
         chk("t6.u0.pulse0", 32'(if0.pulse_out[0]), 32'(j == 4 + FILT));
      end

      // Randomised traffic against the model
      for (int i = 0; i < 600; ) begin
         ra   = CH'($urandom);
         hold = $urandom_range(1, 5);
         for (int b = 0; b < CH; b++) ren[b] = ($urandom_range(0, 99) < 85);
         for (int h = 0; h < hold; h++) begin
            for (int b = 0; b < CH; b++) rclr[b] = ($urandom_range(0, 99) < 6);
            cyc(ra, ren, rclr);
            i++;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
